// File: rtl/jtframe_pkg.sv
// Shared jtframe definitions: PROM loader FSM encoding
// and the legal PROM word widths.
package jtframe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } prom_st_e;

  function automatic bit prom_dw_ok(input int dw);
    return (dw == 8) || (dw == 16);
  endfunction

endpackage

// File: rtl/jtframe_prom_loader.sv
// Captures a PROM region out of the ROM download stream and
// writes it as 8- or 16-bit words, with a running byte checksum.
module jtframe_prom_loader #(
  parameter int AW    = 10,
  parameter int DW    = 8,
  parameter int START = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          downloading,
  input  logic [21:0]   ioctl_addr,
  input  logic [7:0]    ioctl_data,
  input  logic          ioctl_wr,
  output logic          prom_we,
  output logic [AW-1:0] prom_addr,
  output logic [DW-1:0] prom_data,
  output logic          done,
  output logic          incomplete,
  output logic [7:0]    checksum
);
  import jtframe_pkg::*;

  localparam int BSH = DW / 16;
  localparam int OW  = AW + BSH;
  localparam logic [22:0] W_LO = 23'(START);
  localparam logic [22:0] W_HI =
    23'(START + (2 ** AW) * (DW / 8));

  prom_st_e        r_st;
  prom_st_e        w_nxt;
  logic            r_dl_q;
  logic            r_blk;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_data;
  logic            r_done;
  logic            r_inc;
  logic [7:0]      r_sum;

  logic            w_rise;
  logic            w_inwin;
  logic [OW-1:0]   w_off;
  logic            w_last;
  logic            w_acc;
  logic            w_load;
  logic            w_start;
  logic            w_fin;
  logic            w_abort;
  logic            w_wr;
  logic [AW-1:0]   w_waddr;
  logic [DW-1:0]   w_wdata;

  // r_blk keeps a level still high across reset from
  // looking like a fresh download start
  assign w_rise  = downloading & ~r_dl_q & ~r_blk;
  assign w_inwin = ({1'b0, ioctl_addr} >= W_LO) &&
                   ({1'b0, ioctl_addr} <  W_HI);
  assign w_off   = OW'(ioctl_addr - 22'(START));
  assign w_last  = &w_off;
  assign w_acc   = ioctl_wr & downloading &
                   w_load & w_inwin;

  always_ff @(posedge clk) begin
    if (rst) r_st <= ST_IDLE;
    else     r_st <= w_nxt;
  end

  always_comb begin
    w_nxt = r_st;
    unique case (r_st)
      ST_IDLE: if (w_rise) w_nxt = ST_LOAD;
      ST_LOAD: begin
        if (!downloading)
          w_nxt = ST_IDLE;
        else if (w_acc && w_last)
          w_nxt = ST_DONE;
      end
      ST_DONE: if (w_rise) w_nxt = ST_LOAD;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load  = 1'b0;
    w_start = 1'b0;
    w_fin   = 1'b0;
    w_abort = 1'b0;
    unique case (1'b1)
      (r_st == ST_LOAD): begin
        w_load  = 1'b1;
        w_fin   = w_acc & w_last;
        w_abort = ~downloading;
      end
      (r_st == ST_IDLE),
      (r_st == ST_DONE): w_start = w_rise;
      default: ;
    endcase
  end

  if (!prom_dw_ok(DW)) begin : g_bad_dw
    $error("jtframe_prom_loader: DW must be 8 or 16");
  end

  if (DW == 16) begin : g_w16
    logic [7:0] r_lat;
    always_ff @(posedge clk) begin
      if (rst)
        r_lat <= '0;
      else if (w_start)
        r_lat <= '0;
      else if (w_acc && !w_off[0])
        r_lat <= ioctl_data;
    end
    assign w_wr    = w_acc & w_off[0];
    assign w_waddr = w_off[AW:1];
    assign w_wdata = {ioctl_data, r_lat};
  end else begin : g_w8
    assign w_wr    = w_acc;
    assign w_waddr = w_off;
    assign w_wdata = ioctl_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dl_q <= 1'b0;
      r_blk  <= 1'b1;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_done <= 1'b0;
      r_inc  <= 1'b0;
      r_sum  <= '0;
    end else begin
      r_dl_q <= downloading;
      if (!downloading) r_blk <= 1'b0;
      r_we <= w_wr;
      if (w_wr) begin
        r_addr <= w_waddr;
        r_data <= w_wdata;
      end
      if (w_start) begin
        r_sum  <= '0;
        r_done <= 1'b0;
        r_inc  <= 1'b0;
      end else begin
        if (w_acc)   r_sum  <= r_sum + ioctl_data;
        if (w_fin)   r_done <= 1'b1;
        if (w_abort) r_inc  <= 1'b1;
      end
    end
  end

  assign prom_we    = r_we;
  assign prom_addr  = r_addr;
  assign prom_data  = r_data;
  assign done       = r_done;
  assign incomplete = r_inc;
  assign checksum   = r_sum;

endmodule

// File: tb/tb_jtframe_prom_loader.sv
// Directed bench for jtframe_prom_loader: three instances
// covering 8-bit offset, 16-bit packing and full-region loads.
module tb_jtframe_prom_loader;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, rst_c;
  logic        dl_a, dl_b, dl_c;
  logic [21:0] io_addr;
  logic [7:0]  io_data;
  logic        io_wr;

  logic        we_a, done_a, inc_a;
  logic [7:0]  addr_a, data_a, sum_a;
  logic        we_b, done_b, inc_b;
  logic [1:0]  addr_b;
  logic [15:0] data_b;
  logic [7:0]  sum_b;
  logic        we_c, done_c, inc_c;
  logic [7:0]  addr_c, data_c, sum_c;

  int total = 0;
  int bad   = 0;
  int np_a  = 0;
  int np_b  = 0;
  int np_c  = 0;
  int base;

  always #5 clk = ~clk;

  jtframe_prom_loader #(.AW(8), .DW(8), .START(32'h100)) u_a (
    .clk(clk), .rst(rst_a), .downloading(dl_a),
    .ioctl_addr(io_addr), .ioctl_data(io_data),
    .ioctl_wr(io_wr), .prom_we(we_a), .prom_addr(addr_a),
    .prom_data(data_a), .done(done_a),
    .incomplete(inc_a), .checksum(sum_a)
  );

  jtframe_prom_loader #(.AW(2), .DW(16), .START(0)) u_b (
    .clk(clk), .rst(rst_b), .downloading(dl_b),
    .ioctl_addr(io_addr), .ioctl_data(io_data),
    .ioctl_wr(io_wr), .prom_we(we_b), .prom_addr(addr_b),
    .prom_data(data_b), .done(done_b),
    .incomplete(inc_b), .checksum(sum_b)
  );

  jtframe_prom_loader #(.AW(8), .DW(8), .START(0)) u_c (
    .clk(clk), .rst(rst_c), .downloading(dl_c),
    .ioctl_addr(io_addr), .ioctl_data(io_data),
    .ioctl_wr(io_wr), .prom_we(we_c), .prom_addr(addr_c),
    .prom_data(data_c), .done(done_c),
    .incomplete(inc_c), .checksum(sum_c)
  );

  always @(negedge clk) begin
    if (we_a) np_a++;
    if (we_b) np_b++;
    if (we_c) np_c++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [21:0] a,
                         input logic [7:0] d);
    io_addr = a;
    io_data = d;
    io_wr   = 1'b1;
    tick();
    io_wr   = 1'b0;
  endtask

  initial begin
    rst_a = 1; rst_b = 1; rst_c = 1;
    dl_a = 0; dl_b = 0; dl_c = 0;
    io_addr = '0; io_data = '0; io_wr = 0;
    repeat (2) tick();
    rst_a = 0; rst_b = 0; rst_c = 0;
    tick();
    chk("rst_we",   32'(we_a),   0);
    chk("rst_addr", 32'(addr_a), 0);
    chk("rst_data", 32'(data_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_inc",  32'(inc_a),  0);
    chk("rst_sum",  32'(sum_a),  0);

    // 8-bit region at 0x100
    dl_a = 1; tick();
    wr_byte(22'h100, 8'hA5);
    chk("a0_we",   32'(we_a),   1);
    chk("a0_addr", 32'(addr_a), 32'h00);
    chk("a0_data", 32'(data_a), 32'hA5);
    tick();
    chk("a0_pulse1", 32'(we_a),   0);
    chk("a0_hold",   32'(addr_a), 32'h00);
    wr_byte(22'h1FF, 8'h3C);
    chk("a1_we",   32'(we_a),   1);
    chk("a1_addr", 32'(addr_a), 32'hFF);
    chk("a1_data", 32'(data_a), 32'h3C);
    chk("a1_sum",  32'(sum_a),  32'hE1);
    chk("a1_done", 32'(done_a), 1);
    wr_byte(22'h150, 8'h77);
    chk("a_post_done_we",  32'(we_a),  0);
    chk("a_post_done_sum", 32'(sum_a), 32'hE1);

    // out-of-window bytes
    dl_a = 0; tick();
    dl_a = 1; tick();
    chk("a_restart_sum",  32'(sum_a),  0);
    chk("a_restart_done", 32'(done_a), 0);
    base = np_a;
    wr_byte(22'h0FF, 8'h11);
    chk("a_below_we", 32'(we_a), 0);
    wr_byte(22'h200, 8'h22);
    chk("a_above_we", 32'(we_a), 0);
    tick();
    chk("a_oow_pulses", 32'(np_a - base), 0);
    chk("a_oow_sum",    32'(sum_a),       0);
    dl_a = 0; tick();
    chk("a_inc", 32'(inc_a), 1);

    // 16-bit packing
    dl_b = 1; tick();
    wr_byte(22'h0, 8'h34);
    chk("b0_even_we", 32'(we_b), 0);
    wr_byte(22'h1, 8'h12);
    chk("b0_we",   32'(we_b),   1);
    chk("b0_addr", 32'(addr_b), 0);
    chk("b0_data", 32'(data_b), 32'h1234);
    wr_byte(22'h2, 8'h56);
    wr_byte(22'h3, 8'h78);
    chk("b1_addr", 32'(addr_b), 1);
    chk("b1_data", 32'(data_b), 32'h7856);
    wr_byte(22'h4, 8'h9A);
    wr_byte(22'h5, 8'hBC);
    wr_byte(22'h6, 8'hDE);
    chk("b_pre_done", 32'(done_b), 0);
    wr_byte(22'h7, 8'hF0);
    chk("b3_we",   32'(we_b),   1);
    chk("b3_addr", 32'(addr_b), 3);
    chk("b3_data", 32'(data_b), 32'hF0DE);
    chk("b_done",  32'(done_b), 1);
    chk("b_sum",   32'(sum_b),  32'h38);
    tick();
    chk("b_pulses", 32'(np_b), 4);
    dl_b = 0; tick();
    dl_b = 1; tick();
    wr_byte(22'h1, 8'hAA);
    chk("b_odd_first", 32'(data_b), 32'hAA00);
    dl_b = 0; tick();

    // early end of download
    dl_c = 1; tick();
    for (int i = 0; i < 10; i++)
      wr_byte(22'(i), 8'(i));
    io_addr = 22'd10; io_data = 8'h99; io_wr = 1;
    dl_c = 0; tick();
    io_wr = 0;
    chk("c_fall_we",   32'(we_c),   0);
    chk("c_inc",       32'(inc_c),  1);
    chk("c_inc_done",  32'(done_c), 0);
    chk("c_inc_sum",   32'(sum_c),  32'h2D);
    wr_byte(22'd11, 8'h01);
    chk("c_idle_we", 32'(we_c), 0);
    dl_c = 1; tick();
    chk("c_inc_clr", 32'(inc_c), 0);
    chk("c_sum_clr", 32'(sum_c), 0);

    // full back-to-back load
    base = np_c;
    for (int i = 0; i < 256; i++) begin
      wr_byte(22'(i), 8'(i));
      chk("c_seq_we",   32'(we_c),   1);
      chk("c_seq_addr", 32'(addr_c), 32'(i));
    end
    chk("c_full_done", 32'(done_c), 1);
    chk("c_full_sum",  32'(sum_c),  32'h80);
    tick();
    chk("c_full_pulses", 32'(np_c - base), 256);

    // reset in the middle of a load
    dl_c = 0; tick();
    dl_c = 1; tick();
    wr_byte(22'h0, 8'h55);
    chk("c_pre_rst_we", 32'(we_c), 1);
    io_addr = 22'h1; io_data = 8'h66; io_wr = 1;
    rst_c = 1; tick();
    rst_c = 0; io_wr = 0;
    chk("c_rst_we",   32'(we_c),   0);
    chk("c_rst_addr", 32'(addr_c), 0);
    chk("c_rst_data", 32'(data_c), 0);
    chk("c_rst_sum",  32'(sum_c),  0);
    chk("c_rst_done", 32'(done_c), 0);
    chk("c_rst_inc",  32'(inc_c),  0);
    base = np_c;
    wr_byte(22'h2, 8'h21);
    wr_byte(22'h3, 8'h22);
    tick();
    chk("c_rst_nowr", 32'(np_c - base), 0);
    chk("c_rst_sum2", 32'(sum_c),       0);
    dl_c = 0; tick();
    chk("c_rst_noinc", 32'(inc_c), 0);
    dl_c = 1; tick();
    wr_byte(22'h5, 8'h42);
    chk("c_rerise_we",   32'(we_c),   1);
    chk("c_rerise_addr", 32'(addr_c), 5);
    chk("c_rerise_data", 32'(data_c), 32'h42);
    dl_c = 0; tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtframe_prom_loader.md
JTFRAME_PROM_LOADER -- requirements
Module: jtframe_prom_loader

Interface
REQ-001 SHALL have parameter AW, default 10: PROM word-address width.
REQ-002 SHALL have parameter DW, default 8: PROM word width; legal values are 8 and 16.
REQ-003 SHALL have parameter START, default 0: byte offset of the PROM region in the download stream.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port downloading, input, 1 bit: high while a ROM download is in progress.
REQ-007 SHALL have port ioctl_addr, input, 22 bits: byte address in the download stream.
REQ-008 SHALL have port ioctl_data, input, 8 bits: download byte.
REQ-009 SHALL have port ioctl_wr, input, 1 bit: one-cycle byte strobe.
REQ-010 SHALL have port prom_we, output, 1 bit: PROM write pulse.
REQ-011 SHALL have port prom_addr, output, AW bits: PROM write address.
REQ-012 SHALL have port prom_data, output, DW bits: PROM write data.
REQ-013 SHALL have port done, output, 1 bit: complete region loaded.
REQ-014 SHALL have port incomplete, output, 1 bit: download ended before the region was full.
REQ-015 SHALL have port checksum, output, 8 bits: running sum, modulo 256, of in-window bytes.

Function
REQ-016 SHALL define the window as START <= ioctl_addr < START + (2^AW)*(DW/8), where offset = ioctl_addr - START.
REQ-017 SHALL accept a byte only when ioctl_wr=1, downloading=1, the state is LOAD and ioctl_addr is inside the window; all other bytes are ignored with no side effects.
REQ-018 SHALL, for DW=8 on an accepted byte, drive prom_we=1 for exactly one cycle on the following cycle, with prom_addr=offset[AW-1:0] and prom_data=ioctl_data.
REQ-019 SHALL, for DW=16, latch an even-offset byte as the low byte without writing.
REQ-020 SHALL, for DW=16, on an odd-offset byte pulse prom_we on the next cycle with prom_addr=offset[AW:1] and prom_data={byte, latched low byte} (little-endian).
REQ-021 SHALL, for DW=16, use the current latch contents when an odd byte arrives with no preceding even byte.
REQ-022 SHALL hold prom_addr and prom_data stable between pulses.
REQ-023 SHALL add every accepted byte to checksum, wrapping modulo 256.
REQ-024 SHALL implement FSM IDLE/LOAD/DONE; IDLE->LOAD on a rising edge of downloading, which also clears checksum, done, incomplete and the byte latch.
REQ-025 SHALL transition LOAD->DONE, setting done=1, in the cycle the last window byte (offset (2^AW)*(DW/8)-1) is accepted.
REQ-026 SHALL transition LOAD->IDLE, setting incomplete=1, when downloading falls in LOAD.
REQ-027 SHALL hold done in DONE until the next rising edge of downloading (DONE->LOAD) or rst.
REQ-028 SHALL ignore ioctl_wr in the same cycle downloading falls.
REQ-029 SHALL NOT write bytes arriving after DONE; they are outside LOAD.
REQ-030 SHALL accept strobes on back-to-back cycles with no lost bytes.

Reset
REQ-031 SHALL on rst=1 enter IDLE and clear prom_we, prom_addr, prom_data, done, incomplete, checksum, the latch and the downloading edge register, overriding every other input in that cycle.
REQ-032 SHALL, on rst mid-LOAD, issue no further prom_we, and SHALL re-enter LOAD only on a new downloading rising edge.

Structure
REQ-033 SHALL place the FSM state encoding and the DW legality check in the shared jtframe package.
REQ-034 SHALL be a single module with no sub-modules; the window compare and byte packer are inline logic.

Verification
REQ-035 Bench SHALL cover: DW=8, START=0x100; bytes 0xA5@0x100 and 0x3C@0x1FF -> prom_we pulses at addr 0x000 data 0xA5 and at addr 0x0FF data 0x3C; checksum=0xE1.
REQ-036 Bench SHALL cover: DW=16, AW=2, START=0; bytes 0x34@0, 0x12@1 -> single pulse, addr 0, data 0x1234; full 8 bytes -> done=1 on the last accept cycle.
REQ-037 Bench SHALL cover: bytes at 0x0FF and at 0x200 with START=0x100, DW=8, AW=8 -> no prom_we pulses, checksum=0.
REQ-038 Bench SHALL cover: downloading falls after 10 of 256 bytes -> incomplete=1, done=0, state IDLE; a new download clears incomplete.
REQ-039 Bench SHALL cover: rst asserted mid-LOAD with ioctl_wr=1 -> prom_we=0 next cycle, all outputs 0, no writes until a downloading re-rise.
REQ-040 Bench SHALL cover: 256 back-to-back strobes (DW=8, AW=8) -> exactly 256 pulses, addresses 0..255 in order, done=1.
